// File: rtl/ap_hs_pkg.sv
// rtl/ap_hs_pkg.sv - shared widths, record layout and queue-op encoding for the ap_ctrl_hs tracker
package ap_hs_pkg;

  localparam int AP_HS_TS_W    = 32;
  localparam int AP_HS_ID_W    = 16;
  localparam int AP_HS_STALL_W = 16;

  // One completed transaction as it leaves on the record stream (MSB first).
  typedef struct packed {
    logic [AP_HS_STALL_W-1:0] stall;
    logic [AP_HS_ID_W-1:0]    id;
    logic [AP_HS_TS_W-1:0]    latency;
    logic [AP_HS_TS_W-1:0]    start_ts;
  } ap_hs_rec_t;

  localparam int REC_W = $bits(ap_hs_rec_t);

  // What the start-time queue does in a given cycle.
  typedef enum logic [1:0] {
    Q_HOLD = 2'd0,
    Q_PUSH = 2'd1,
    Q_POP  = 2'd2,
    Q_SWAP = 2'd3
  } ap_hs_qop_t;

  // Record width for a non-default timestamp width (same field order as ap_hs_rec_t).
  function automatic int ap_hs_rec_w(input int ts_w);
    return 2 * ts_w + AP_HS_ID_W + AP_HS_STALL_W;
  endfunction

endpackage

// File: rtl/ap_hs_rec_fifo.sv
// rtl/ap_hs_rec_fifo.sv - synchronous record FIFO with full/empty, write accepted when full if a pop happens the same cycle
module ap_hs_rec_fifo
  import ap_hs_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_tvalid,
  input  logic [WIDTH-1:0] wr_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd     = rd_tready & ~empty;
  assign do_wr     = wr_tvalid & (~full | do_rd);
  assign rd_tvalid = ~empty;
  assign rd_tdata  = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Record storage; contents are only meaningful behind a valid pointer so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_tdata;
  end

endmodule

// File: rtl/ap_hs_txn_tracker.sv
// rtl/ap_hs_txn_tracker.sv - pairs ap_ctrl_hs starts with completions and streams one timestamped record per transaction
// Optional build macro: AP_HS_STALL_CNT_EN adds a per-transaction count of ap_start-without-ap_ready cycles.
module ap_hs_txn_tracker
  import ap_hs_pkg::*;
#(
  parameter int  TS_W    = AP_HS_TS_W,
  parameter int  MAX_OUT = 4,
  parameter int  DEPTH   = 8,
  localparam int RW      = ap_hs_rec_w(TS_W)
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_start,
  input  logic          ap_ready,
  input  logic          ap_done,
  input  logic          ap_continue,
  input  logic          finish,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [RW-1:0] rec_data,
  output logic [15:0]   txn_count,
  output logic [15:0]   drop_cnt,
  output logic          err_overrun,
  output logic          err_underrun,
  output logic          idle
);

  localparam int QPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int QCW = $clog2(MAX_OUT + 1);

  logic [TS_W-1:0] cyc_cnt;

  // Start queue: circular buffer of start timestamps and ids.
  logic [TS_W-1:0] q_ts [MAX_OUT];
  logic [15:0]     q_id [MAX_OUT];
  logic [QPW-1:0]  q_rd;
  logic [QPW-1:0]  q_wr;
  logic [QCW-1:0]  q_cnt;
  logic            q_empty;
  logic            q_full;

  logic            acc;
  logic            done;
  logic            push;
  logic            pop;
  logic            overrun_set;
  logic            underrun_set;
  logic            rec_wr;
  logic            drop;
  ap_hs_qop_t      qop;

  logic [TS_W-1:0] head_ts;
  logic [15:0]     head_id;
  logic [15:0]     head_stall;
  logic [RW-1:0]   rec_in;
  logic            fifo_full;
  logic            fifo_empty;

  assign acc     = ap_start & ap_ready & ~finish;
  assign done    = ap_done & ap_continue & ~finish;
  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == QCW'(MAX_OUT));

  // A DONE meeting an ACC on an empty queue bypasses storage; a DONE frees a slot so ACC may push even when full.
  assign pop          = done & ~q_empty;
  assign push         = acc & (q_empty ? ~done : (~q_full | done));
  assign overrun_set  = acc & q_full & ~done;
  assign underrun_set = done & q_empty & ~acc;
  assign rec_wr       = done & (acc | ~q_empty);
  assign drop         = rec_wr & fifo_full & ~(rec_valid & rec_ready);

  // Classify the queue operation for this cycle.
  always_comb begin
    qop = Q_HOLD;
    if (push && pop)  qop = Q_SWAP;
    else if (push)    qop = Q_PUSH;
    else if (pop)     qop = Q_POP;
  end

  // Free-running cycle counter used as the timestamp base.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) cyc_cnt <= '0;
    else           cyc_cnt <= cyc_cnt + TS_W'(1);
  end

  // Queue pointers and occupancy.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      case (qop)
        Q_PUSH: begin
          q_wr  <= (q_wr == QPW'(MAX_OUT - 1)) ? '0 : q_wr + QPW'(1);
          q_cnt <= q_cnt + QCW'(1);
        end
        Q_POP: begin
          q_rd  <= (q_rd == QPW'(MAX_OUT - 1)) ? '0 : q_rd + QPW'(1);
          q_cnt <= q_cnt - QCW'(1);
        end
        Q_SWAP: begin
          q_wr  <= (q_wr == QPW'(MAX_OUT - 1)) ? '0 : q_wr + QPW'(1);
          q_rd  <= (q_rd == QPW'(MAX_OUT - 1)) ? '0 : q_rd + QPW'(1);
        end
        default: ;
      endcase
    end
  end

  // Capture start timestamp and id of each queued transaction.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        q_ts[i] <= '0;
        q_id[i] <= '0;
      end
    end else if (push) begin
      q_ts[q_wr] <= cyc_cnt;
      q_id[q_wr] <= txn_count;
    end
  end

`ifdef AP_HS_STALL_CNT_EN
  logic [15:0] stall_run;
  logic [15:0] q_stall [MAX_OUT];

  // Count cycles the DUT is offered a start but not ready; restarts at every accepted handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                                                   stall_run <= '0;
    else if (acc)                                                    stall_run <= '0;
    else if (ap_start && !ap_ready && !finish && stall_run != 16'hFFFF) stall_run <= stall_run + 16'd1;
  end

  // Store the stall count alongside the start timestamp.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) q_stall[i] <= '0;
    end else if (push) begin
      q_stall[q_wr] <= stall_run;
    end
  end

  assign head_stall = q_empty ? stall_run : q_stall[q_rd];
`else
  assign head_stall = '0;
`endif

  // Build the record from the queue head, or from the current cycle for a bypassed transaction.
  always_comb begin
    head_ts = q_empty ? cyc_cnt : q_ts[q_rd];
    head_id = q_empty ? txn_count : q_id[q_rd];
    rec_in  = {head_stall, head_id, cyc_cnt - head_ts, head_ts};
  end

  // Transaction count, drop count and sticky error flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      txn_count    <= '0;
      drop_cnt     <= '0;
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (acc && !overrun_set)          txn_count    <= txn_count + 16'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt     <= drop_cnt + 16'd1;
      if (overrun_set)                  err_overrun  <= 1'b1;
      if (underrun_set)                 err_underrun <= 1'b1;
    end
  end

  ap_hs_rec_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_rec_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .wr_tvalid (rec_wr),
    .wr_tdata  (rec_in),
    .rd_tvalid (rec_valid),
    .rd_tready (rec_ready),
    .rd_tdata  (rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign idle = q_empty & fifo_empty;

endmodule

// File: tb/tb_ap_hs_txn_tracker.sv
// tb/tb_ap_hs_txn_tracker.sv - self-checking bench for ap_hs_txn_tracker with a queue-based reference model
module tb_ap_hs_txn_tracker;

  localparam int TS_W = 32, MAX_OUT = 4, DEPTH = 8, RW = 2 * TS_W + 32;
  localparam int W8 = 8, RW8 = 2 * W8 + 32;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0, finish = 1'b0, rec_ready = 1'b0;
  logic rec_valid, err_overrun, err_underrun, idle;
  logic [RW-1:0] rec_data;
  logic [15:0] txn_count, drop_cnt;

  logic b_start = 1'b0, b_ready = 1'b0, b_done = 1'b0, b_continue = 1'b0, b_finish = 1'b0, b_rec_ready = 1'b0;
  logic b_rec_valid, b_err_overrun, b_err_underrun, b_idle;
  logic [RW8-1:0] b_rec_data;
  logic [15:0] b_txn_count, b_drop_cnt;

  always #5 ap_clk = ~ap_clk;

  ap_hs_txn_tracker #(.TS_W(TS_W), .MAX_OUT(MAX_OUT), .DEPTH(DEPTH)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .txn_count(txn_count), .drop_cnt(drop_cnt), .err_overrun(err_overrun),
    .err_underrun(err_underrun), .idle(idle)
  );

  ap_hs_txn_tracker #(.TS_W(W8), .MAX_OUT(MAX_OUT), .DEPTH(DEPTH)) u_w8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(b_start), .ap_ready(b_ready),
    .ap_done(b_done), .ap_continue(b_continue), .finish(b_finish),
    .rec_valid(b_rec_valid), .rec_ready(b_rec_ready), .rec_data(b_rec_data),
    .txn_count(b_txn_count), .drop_cnt(b_drop_cnt), .err_overrun(b_err_overrun),
    .err_underrun(b_err_underrun), .idle(b_idle)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the 32-bit instance: transactions kept in queues, evaluated once per clock.
  logic [31:0] m_cyc;
  logic [15:0] m_txn, m_drop;
  logic        m_ovr, m_und;
  logic [31:0] sq_ts[$];
  logic [15:0] sq_id[$];
  logic [RW-1:0] rq[$];
  logic        m_acc, m_dn, m_have, m_pop;
  int          m_n, m_fn;
  logic [RW-1:0] m_rec, m_tmp;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_cyc = 0; m_txn = 0; m_drop = 0; m_ovr = 0; m_und = 0;
      sq_ts.delete(); sq_id.delete(); rq.delete();
    end else begin
      m_acc  = ap_start & ap_ready & ~finish;
      m_dn   = ap_done & ap_continue & ~finish;
      m_n    = sq_ts.size();
      m_fn   = rq.size();
      m_pop  = rec_ready && (m_fn != 0);
      m_have = 1'b0;
      if (m_dn && m_n > 0) begin
        m_rec = {16'h0, sq_id[0], m_cyc - sq_ts[0], sq_ts[0]};
        sq_ts.pop_front(); sq_id.pop_front();
        m_have = 1'b1;
      end else if (m_dn && m_acc) begin
        m_rec = {16'h0, m_txn, 32'h0, m_cyc};
        m_have = 1'b1;
      end else if (m_dn) begin
        m_und = 1'b1;
      end
      if (m_acc) begin
        if (m_n == MAX_OUT && !m_dn) m_ovr = 1'b1;
        else begin
          if (!(m_dn && m_n == 0)) begin
            sq_ts.push_back(m_cyc);
            sq_id.push_back(m_txn);
          end
          m_txn = m_txn + 16'd1;
        end
      end
      if (m_pop) m_tmp = rq.pop_front();
      if (m_have) begin
        if (m_fn == DEPTH && !m_pop) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else rq.push_back(m_rec);
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  task automatic clear_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0; rec_ready = 0;
    b_start = 0; b_ready = 0; b_done = 0; b_continue = 0; b_finish = 0; b_rec_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    clear_inputs();
    ap_rst_n = 0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1;
  endtask

  task automatic wait_cyc(input logic [31:0] target);
    for (int i = 0; i < 3000 && m_cyc != target; i++) @(negedge ap_clk);
    checks++;
    if (m_cyc != target) begin
      errors++;
      $display("FAIL wait_cyc got %0d want %0d", m_cyc, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    ap_done = 1; ap_continue = 1;
    @(negedge ap_clk);
    ap_start = 1; ap_ready = 1;
    @(negedge ap_clk);
    ap_done = 0; ap_continue = 0;
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    checks++;
    if ({rec_valid, idle, txn_count, err_underrun} !== {1'b1, 1'b0, 16'd2, 1'b1}) begin
      errors++;
      $display("FAIL reset_pre got v=%b idle=%b txn=%0d und=%b want 1 0 2 1", rec_valid, idle, txn_count, err_underrun);
    end
    #2 ap_rst_n = 0;
    #1;
    checks++;
    if ({rec_valid, idle, txn_count, drop_cnt, err_overrun, err_underrun} !== {1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got v=%b idle=%b txn=%0d drop=%0d ovr=%b und=%b want 0 1 0 0 0 0",
               rec_valid, idle, txn_count, drop_cnt, err_overrun, err_underrun);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    wait_cyc(10);
    ap_start = 1; ap_ready = 1;
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    wait_cyc(13);
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rec_valid); end
    ap_done = 1; ap_continue = 1;
    @(negedge ap_clk);
    ap_done = 0; ap_continue = 0;
    checks++;
    if ({rec_valid, rec_data} !== {1'b1, 16'h0, 16'd0, 32'd3, 32'd10}) begin
      errors++;
      $display("FAIL single_rec got v=%b data=%h want v=1 id=0 lat=3 ts=10", rec_valid, rec_data);
    end
    @(negedge ap_clk);
    checks++;
    if ({rec_valid, rec_data[63:0]} !== {1'b1, 32'd3, 32'd10}) begin
      errors++;
      $display("FAIL single_hold got v=%b data=%h", rec_valid, rec_data);
    end
    rec_ready = 1;
    @(negedge ap_clk);
    rec_ready = 0;
    checks++;
    if ({rec_valid, idle, txn_count} !== {1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL single_drain got v=%b idle=%b txn=%0d want 0 1 1", rec_valid, idle, txn_count);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    wait_cyc(5);
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    @(negedge ap_clk);
    clear_inputs();
    checks++;
    if ({rec_valid, rec_data, txn_count, err_underrun} !== {1'b1, 16'h0, 16'd0, 32'd0, 32'd5, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL bypass got v=%b data=%h txn=%0d und=%b want id=0 lat=0 ts=5 txn=1", rec_valid, rec_data, txn_count, err_underrun);
    end
  endtask

  task automatic test_pipelined();
    logic [31:0] s0, d0;
    do_reset();
    s0 = m_cyc;
    ap_start = 1; ap_ready = 1;
    repeat (5) @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    checks++;
    if ({txn_count, err_overrun, idle} !== {16'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pipe_overrun got txn=%0d ovr=%b idle=%b want 4 1 0", txn_count, err_overrun, idle);
    end
    @(negedge ap_clk);
    d0 = m_cyc;
    ap_done = 1; ap_continue = 1;
    repeat (4) @(negedge ap_clk);
    ap_done = 0; ap_continue = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rec_valid, rec_data[79:64], rec_data[63:32]} !== {1'b1, 16'(i), d0 - s0}) begin
        errors++;
        $display("FAIL pipe_rec%0d got v=%b id=%0d lat=%0d want id=%0d lat=%0d", i, rec_valid, rec_data[79:64], rec_data[63:32], i, d0 - s0);
      end
      rec_ready = 1;
      @(negedge ap_clk);
      rec_ready = 0;
    end
    checks++;
    if ({idle, err_underrun} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pipe_idle got idle=%b und=%b want 1 0", idle, err_underrun);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_id;
    do_reset();
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    repeat (10) @(negedge ap_clk);
    checks++;
    if ({drop_cnt, txn_count, rec_valid, rec_data[79:64]} !== {16'd2, 16'd10, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL bp_full got drop=%0d txn=%0d v=%b id=%0d want 2 10 1 0", drop_cnt, txn_count, rec_valid, rec_data[79:64]);
    end
    rec_ready = 1;
    @(negedge ap_clk);
    clear_inputs();
    checks++;
    if ({drop_cnt, rec_data[79:64]} !== {16'd2, 16'd1}) begin
      errors++;
      $display("FAIL bp_wr_pop got drop=%0d id=%0d want 2 1", drop_cnt, rec_data[79:64]);
    end
    for (int i = 0; i < 8; i++) begin
      exp_id = (i < 7) ? 16'(i + 1) : 16'd10;
      checks++;
      if ({rec_valid, rec_data[79:64]} !== {1'b1, exp_id}) begin
        errors++;
        $display("FAIL bp_drain%0d got v=%b id=%0d want 1 %0d", i, rec_valid, rec_data[79:64], exp_id);
      end
      rec_ready = 1;
      @(negedge ap_clk);
      rec_ready = 0;
    end
    checks++;
    if ({rec_valid, idle} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_empty got v=%b idle=%b want 0 1", rec_valid, idle);
    end
  endtask

  task automatic test_finish();
    do_reset();
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    @(negedge ap_clk);
    finish = 1;
    repeat (3) @(negedge ap_clk);
    checks++;
    if ({txn_count, err_overrun, err_underrun, rec_valid, idle} !== {16'd1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL finish_freeze got txn=%0d ovr=%b und=%b v=%b idle=%b want 1 0 0 1 0",
               txn_count, err_overrun, err_underrun, rec_valid, idle);
    end
    rec_ready = 1;
    @(negedge ap_clk);
    checks++;
    if ({rec_valid, idle} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL finish_drain got v=%b idle=%b want 0 1", rec_valid, idle);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    wait_cyc(250);
    b_start = 1; b_ready = 1;
    @(negedge ap_clk);
    b_start = 0; b_ready = 0;
    wait_cyc(260);
    b_done = 1; b_continue = 1;
    @(negedge ap_clk);
    b_done = 0; b_continue = 0;
    checks++;
    if ({b_rec_valid, b_rec_data[15:8], b_rec_data[7:0]} !== {1'b1, 8'd10, 8'd250}) begin
      errors++;
      $display("FAIL wrap_lat got v=%b lat=%0d ts=%0d want 1 10 250", b_rec_valid, b_rec_data[15:8], b_rec_data[7:0]);
    end
    b_rec_ready = 1; b_done = 1; b_continue = 1;
    @(negedge ap_clk);
    b_rec_ready = 0; b_done = 0; b_continue = 0;
    @(negedge ap_clk);
    checks++;
    if ({b_err_underrun, b_rec_valid, b_idle} !== {1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_underrun got und=%b v=%b idle=%b want 1 0 1", b_err_underrun, b_rec_valid, b_idle);
    end
  endtask

  task automatic test_random();
    logic e_valid, e_idle;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      ap_start    = ($urandom_range(0, 99) < 55);
      ap_ready    = ($urandom_range(0, 99) < 60);
      ap_done     = ($urandom_range(0, 99) < 40);
      ap_continue = ($urandom_range(0, 99) < 80);
      finish      = ($urandom_range(0, 15) == 0);
      rec_ready   = ((i % 300) < 150) ? ($urandom_range(0, 99) < 50) : 1'b0;
      @(negedge ap_clk);
      e_valid = (rq.size() != 0);
      e_idle  = (sq_ts.size() == 0) && (rq.size() == 0);
      checks++;
      if ({rec_valid, txn_count, drop_cnt, err_overrun, err_underrun, idle} !== {e_valid, m_txn, m_drop, m_ovr, m_und, e_idle}) begin
        errors++;
        $display("FAIL rand_state@%0d got v=%b txn=%0d drop=%0d ovr=%b und=%b idle=%b want %b %0d %0d %b %b %b",
                 i, rec_valid, txn_count, drop_cnt, err_overrun, err_underrun, idle, e_valid, m_txn, m_drop, m_ovr, m_und, e_idle);
      end
      if (e_valid) begin
        checks++;
        if (rec_data !== rq[0]) begin
          errors++;
          $display("FAIL rand_data@%0d got %h want %h", i, rec_data, rq[0]);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_bypass();
    test_pipelined();
    test_backpressure();
    test_finish();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
